// File: rtl/uart_stream_bridge.sv
// Byte-stream bridge to the UART register port: TX/RX FIFOs plus a poll FSM
// that moves one byte per UART strobe whenever the UART status allows it.
module uart_stream_bridge #(
  parameter int DEPTH    = 16,
  parameter int POLL_GAP = 4
) (
  input  logic                   CLK,
  input  logic                   RES,
  input  logic [7:0]             TX_DATA,
  input  logic                   TX_VALID,
  output logic                   TX_READY,
  output logic [7:0]             RX_DATA,
  output logic                   RX_VALID,
  input  logic                   RX_READY,
  output logic [$clog2(DEPTH):0] TX_LEVEL,
  output logic [$clog2(DEPTH):0] RX_LEVEL,
  output logic                   RX_STALL,
  input  logic                   STALL_CLR,
  output logic                   UART_RD,
  output logic                   UART_WR,
  output logic [3:0]             UART_BE,
  output logic [31:0]            UART_DATAI,
  input  logic [31:0]            UART_DATAO
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(POLL_GAP);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POLL   = 3'd1,
    RXPOP  = 3'd2,
    TXPUSH = 3'd3,
    SETTLE = 3'd4
  } state_t;

  logic [7:0]    tx_mem_r [DEPTH];
  logic [7:0]    rx_mem_r [DEPTH];
  logic [LW-1:0] tx_wr_r, tx_rd_r, rx_wr_r, rx_rd_r, tx_level_r, rx_level_r;
  logic [LW-1:0] tx_wr_nxt_s, tx_rd_nxt_s, rx_wr_nxt_s, rx_rd_nxt_s, rx_rd_inc_s;
  logic          tx_ready_r, rx_valid_r, rx_stall_r, uart_rd_r, uart_wr_r;
  logic [3:0]    uart_be_r, be_nxt_s;
  logic [31:0]   uart_datai_r, datai_nxt_s;
  logic [7:0]    rx_data_r, rx_head_nxt_s, rx_byte_s;
  logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic          tx_empty_s, rx_full_s, stall_set_s;
  state_t        state_r, state_nxt_s;
  logic [GW-1:0] gap_r, gap_nxt_s;
  logic          unused_s;

  assign unused_s  = ^{UART_DATAO[31:16], UART_DATAO[7:2]};
  assign rx_byte_s = UART_DATAO[15:8];

  assign tx_empty_s = (tx_level_r == LW'(0));
  assign rx_full_s  = (rx_level_r == FULL_LVL);
  assign tx_push_s  = TX_VALID & tx_ready_r;
  assign tx_pop_s   = uart_wr_r & ~tx_empty_s;
  assign rx_push_s  = uart_rd_r & ~rx_full_s;
  assign rx_pop_s   = rx_valid_r & RX_READY;

  assign tx_wr_nxt_s = tx_wr_r + {{AW{1'b0}}, tx_push_s};
  assign tx_rd_nxt_s = tx_rd_r + {{AW{1'b0}}, tx_pop_s};
  assign rx_wr_nxt_s = rx_wr_r + {{AW{1'b0}}, rx_push_s};
  assign rx_rd_inc_s = rx_rd_r + LW'(1);
  assign rx_rd_nxt_s = rx_pop_s ? rx_rd_inc_s : rx_rd_r;

  assign TX_READY   = tx_ready_r;
  assign RX_VALID   = rx_valid_r;
  assign RX_DATA    = rx_data_r;
  assign TX_LEVEL   = tx_level_r;
  assign RX_LEVEL   = rx_level_r;
  assign RX_STALL   = rx_stall_r;
  assign UART_RD    = uart_rd_r;
  assign UART_WR    = uart_wr_r;
  assign UART_BE    = uart_be_r;
  assign UART_DATAI = uart_datai_r;

  // FIFO storage writes; contents need no reset since levels gate every read
  always_ff @(posedge CLK) begin
    if (tx_push_s) tx_mem_r[tx_wr_r[AW-1:0]] <= TX_DATA;
    if (rx_push_s) rx_mem_r[rx_wr_r[AW-1:0]] <= rx_byte_s;
  end

  // Next RX head: the pushed byte bypasses memory when it becomes the head
  always_comb begin
    rx_head_nxt_s = rx_data_r;
    if (rx_pop_s) begin
      if (rx_level_r == LW'(1)) begin
        rx_head_nxt_s = rx_push_s ? rx_byte_s : rx_data_r;
      end else begin
        rx_head_nxt_s = rx_mem_r[rx_rd_inc_s[AW-1:0]];
      end
    end else if (rx_push_s && (rx_level_r == LW'(0))) begin
      rx_head_nxt_s = rx_byte_s;
    end else begin
      rx_head_nxt_s = rx_data_r;
    end
  end

  // Poll FSM next state, gap counter and strobe values for the next cycle
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_r;
    stall_set_s = 1'b0;
    be_nxt_s    = 4'b0000;
    datai_nxt_s = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (gap_r <= GW'(1)) begin
          state_nxt_s = POLL;
          gap_nxt_s   = GW'(0);
        end else begin
          gap_nxt_s = gap_r - GW'(1);
        end
      end
      POLL: begin
        if (UART_DATAO[1] && !rx_full_s) begin
          state_nxt_s = RXPOP;
        end else begin
          // A waiting byte we cannot accept is left in the UART
          stall_set_s = UART_DATAO[1];
          if (!UART_DATAO[0] && !tx_empty_s) begin
            state_nxt_s = TXPUSH;
          end else begin
            state_nxt_s = IDLE;
            gap_nxt_s   = GAP_RELOAD;
          end
        end
      end
      RXPOP:  state_nxt_s = SETTLE;
      TXPUSH: state_nxt_s = SETTLE;
      SETTLE: begin
        if (POLL_GAP == 0) begin
          state_nxt_s = POLL;
        end else begin
          state_nxt_s = IDLE;
          gap_nxt_s   = GAP_RELOAD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gap_nxt_s   = GAP_RELOAD;
      end
    endcase
    if (state_nxt_s == RXPOP) begin
      be_nxt_s = 4'b0011;
    end else if (state_nxt_s == TXPUSH) begin
      be_nxt_s    = 4'b0010;
      datai_nxt_s = {16'h0000, tx_mem_r[tx_rd_r[AW-1:0]], 8'h00};
    end else begin
      be_nxt_s    = 4'b0000;
      datai_nxt_s = 32'h0000_0000;
    end
  end

  // State, pointers, registered flags/levels and registered UART strobes
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r      <= IDLE;
      gap_r        <= GAP_RELOAD;
      tx_wr_r      <= LW'(0);
      tx_rd_r      <= LW'(0);
      rx_wr_r      <= LW'(0);
      rx_rd_r      <= LW'(0);
      tx_level_r   <= LW'(0);
      rx_level_r   <= LW'(0);
      tx_ready_r   <= 1'b0;
      rx_valid_r   <= 1'b0;
      rx_data_r    <= 8'h00;
      rx_stall_r   <= 1'b0;
      uart_rd_r    <= 1'b0;
      uart_wr_r    <= 1'b0;
      uart_be_r    <= 4'b0000;
      uart_datai_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      gap_r        <= gap_nxt_s;
      tx_wr_r      <= tx_wr_nxt_s;
      tx_rd_r      <= tx_rd_nxt_s;
      rx_wr_r      <= rx_wr_nxt_s;
      rx_rd_r      <= rx_rd_nxt_s;
      tx_level_r   <= tx_wr_nxt_s - tx_rd_nxt_s;
      rx_level_r   <= rx_wr_nxt_s - rx_rd_nxt_s;
      tx_ready_r   <= ((tx_wr_nxt_s - tx_rd_nxt_s) != FULL_LVL);
      rx_valid_r   <= (rx_wr_nxt_s != rx_rd_nxt_s);
      rx_data_r    <= rx_head_nxt_s;
      rx_stall_r   <= STALL_CLR ? 1'b0 : (rx_stall_r | stall_set_s);
      uart_rd_r    <= (state_nxt_s == RXPOP);
      uart_wr_r    <= (state_nxt_s == TXPUSH);
      uart_be_r    <= be_nxt_s;
      uart_datai_r <= datai_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Bench for uart_stream_bridge: queue-based FIFO model checked every cycle,
// a small UART model, and directed scenarios with literal expectations.
module tb_uart_stream_bridge;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [4:0]  tx_level, rx_level;
  logic        rx_stall;
  logic        stall_clr = 1'b0;
  logic        uart_rd, uart_wr;
  logic [3:0]  uart_be;
  logic [31:0] uart_datai, uart_datao;

  logic        busy = 1'b0;
  logic [7:0]  uart_bytes [64];
  int          u_idx = 0, u_cnt = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
  int          last_rd_cyc = 0, last_wr_cyc = 0;
  logic [7:0]  wr_bytes [256];
  int          wr_cycs [256];
  logic [7:0]  m_tx [$];
  logic [7:0]  m_rx [$];
  bit          tx_full_m, rx_full_m;
  int          checks = 0, errors = 0;

  uart_stream_bridge #(.DEPTH(16), .POLL_GAP(4)) dut (
    .CLK(clk), .RES(res),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
    .TX_LEVEL(tx_level), .RX_LEVEL(rx_level),
    .RX_STALL(rx_stall), .STALL_CLR(stall_clr),
    .UART_RD(uart_rd), .UART_WR(uart_wr), .UART_BE(uart_be),
    .UART_DATAI(uart_datai), .UART_DATAO(uart_datao)
  );

  always #5 clk = ~clk;

  assign uart_datao = {16'h0000, uart_bytes[u_idx % 64], 6'b000000, (u_idx < u_cnt), busy};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // UART side: consume a byte on each read strobe, log each written byte
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_rd) begin
      u_idx       <= u_idx + 1;
      rd_cnt      <= rd_cnt + 1;
      last_rd_cyc <= cyc;
    end
    if (uart_wr) begin
      wr_bytes[wr_cnt % 256] <= uart_datai[15:8];
      wr_cycs[wr_cnt % 256]  <= cyc;
      wr_cnt                 <= wr_cnt + 1;
      last_wr_cyc            <= cyc;
    end
  end

  // Compare against the queue model, then advance the model to the next edge
  always @(negedge clk) begin
    if (res) begin
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_tx_level", tx_level, 0);
      chk("rst_rx_level", rx_level, 0);
      chk("rst_rx_stall", rx_stall, 0);
      chk("rst_strobes", {uart_rd, uart_wr, uart_be}, 0);
      chk("rst_datai", uart_datai, 0);
      m_tx.delete();
      m_rx.delete();
    end else begin
      chk("tx_level", tx_level, m_tx.size());
      chk("tx_ready", tx_ready, m_tx.size() < 16);
      chk("rx_level", rx_level, m_rx.size());
      chk("rx_valid", rx_valid, m_rx.size() > 0);
      if (m_rx.size() > 0) chk("rx_data", rx_data, m_rx[0]);
      chk("rd_wr_exclusive", uart_rd & uart_wr, 0);
      if (uart_wr) begin
        chk("wr_be", uart_be, 4'b0010);
        chk("wr_nonempty", m_tx.size() > 0, 1);
        if (m_tx.size() > 0) chk("wr_datai", uart_datai, {16'h0000, m_tx[0], 8'h00});
      end else if (uart_rd) begin
        chk("rd_be", uart_be, 4'b0011);
        chk("rd_datai", uart_datai, 0);
        chk("rd_space", m_rx.size() < 16, 1);
      end else begin
        chk("idle_be", uart_be, 0);
        chk("idle_datai", uart_datai, 0);
      end
      tx_full_m = (m_tx.size() >= 16);
      rx_full_m = (m_rx.size() >= 16);
      if (uart_wr && m_tx.size() > 0) void'(m_tx.pop_front());
      if (tx_valid && !tx_full_m) m_tx.push_back(tx_data);
      if (rx_ready && m_rx.size() > 0) void'(m_rx.pop_front());
      if (uart_rd && !rx_full_m) m_rx.push_back(uart_datao[15:8]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rd0, wr0, base, k;
    bit found;
    for (int i = 0; i < 64; i++) uart_bytes[i] = 8'h00;
    #1 res = 1'b1;
    repeat (3) @(negedge clk);
    #1 res = 1'b0;
    tick;
    chk("tx_ready_after_rst", tx_ready, 1);

    // Two TX bytes with the UART idle
    tx_valid = 1'b1; tx_data = 8'h41; tick;
    tx_data = 8'h42; tick;
    tx_valid = 1'b0;
    n = 0;
    while (wr_cnt < 2 && n < 200) begin tick; n++; end
    chk("t1_wr_count", wr_cnt, 2);
    chk("t1_byte0", wr_bytes[0], 8'h41);
    chk("t1_byte1", wr_bytes[1], 8'h42);
    chk("t1_wr_gap_ge7", (wr_cycs[1] - wr_cycs[0]) >= 7, 1);
    repeat (3) tick;
    chk("t1_tx_level", tx_level, 0);

    // One RX byte from the UART
    uart_bytes[u_idx % 64] = 8'h5A; u_cnt = u_idx + 1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_rd) begin found = 1'b1; break; end
    end
    chk("t2_rd_seen", found, 1);
    chk("t2_rd_be", uart_be, 4'b0011);
    @(negedge clk);
    chk("t2_rx_valid", rx_valid, 1);
    chk("t2_rx_data", rx_data, 8'h5A);
    chk("t2_rx_level", rx_level, 1);
    repeat (20) @(negedge clk);
    chk("t2_rd_once", rd_cnt, 1);
    tick; rx_ready = 1'b1; tick; rx_ready = 1'b0; tick;
    chk("t2_rx_popped", rx_level, 0);

    // RX ready and TX pending in the same poll: RX goes first
    busy = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h77; tick;
    tx_valid = 1'b0;
    repeat (10) tick;
    rd0 = rd_cnt; wr0 = wr_cnt;
    uart_bytes[u_idx % 64] = 8'h33; u_cnt = u_idx + 1; busy = 1'b0;
    n = 0;
    while (wr_cnt == wr0 && n < 100) begin tick; n++; end
    chk("t3_rd_count", rd_cnt, rd0 + 1);
    chk("t3_rd_to_wr", last_wr_cyc - last_rd_cyc, 7);
    chk("t3_wr_byte", wr_bytes[wr0], 8'h77);
    chk("t3_rx_data", rx_data, 8'h33);
    rx_ready = 1'b1; tick; rx_ready = 1'b0; tick;

    // RX fill with stalled consumer
    base = u_idx; rd0 = rd_cnt;
    for (int i = 0; i < 20; i++) uart_bytes[(base + i) % 64] = 8'h80 + 8'(i);
    u_cnt = base + 20;
    n = 0;
    while (rx_level != 5'd16 && n < 300) begin tick; n++; end
    chk("t4_rx_full", rx_level, 16);
    chk("t4_rx_head", rx_data, 8'h80);
    repeat (30) tick;
    chk("t4_rd_stopped", rd_cnt - rd0, 16);
    chk("t4_stall_set", rx_stall, 1);
    stall_clr = 1'b1; tick; stall_clr = 1'b0;
    chk("t4_stall_clr", rx_stall, 0);
    rx_ready = 1'b1; tick; rx_ready = 1'b0;
    n = 0;
    while (rd_cnt != rd0 + 17 && n < 50) begin tick; n++; end
    chk("t4_resume", rd_cnt - rd0, 17);
    rx_ready = 1'b1;
    n = 0;
    while ((u_idx < u_cnt || rx_level != 5'd0) && n < 400) begin tick; n++; end
    rx_ready = 1'b0;
    chk("t4_drained", rx_level, 0);
    chk("t4_all_read", rd_cnt - rd0, 20);
    stall_clr = 1'b1; tick; stall_clr = 1'b0; repeat (3) tick;
    chk("t4_stall_final", rx_stall, 0);

    // TX fill to full while busy, drain, then a second fill across the wrap
    for (int pass = 0; pass < 2; pass++) begin
      busy = 1'b1; tick;
      tx_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
        tx_data = (pass == 0) ? 8'(i) : 8'hA0 + 8'(i);
        tick;
      end
      tx_valid = 1'b0;
      chk("t5_tx_full_level", tx_level, 16);
      chk("t5_tx_not_ready", tx_ready, 0);
      wr0 = wr_cnt; busy = 1'b0;
      n = 0;
      while (wr_cnt < wr0 + 16 && n < 400) begin tick; n++; end
      repeat (20) tick;
      chk("t5_wr_count", wr_cnt - wr0, 16);
      for (int i = 0; i < 16; i++)
        chk("t5_order", wr_bytes[(wr0 + i) % 256], (pass == 0) ? 8'(i) : 8'hA0 + 8'(i));
    end

    // Async reset during a TXPUSH cycle
    uart_bytes[u_idx % 64] = 8'h11; u_cnt = u_idx + 1;
    n = 0;
    while (rx_level != 5'd1 && n < 100) begin tick; n++; end
    tx_valid = 1'b1; tx_data = 8'h55; tick;
    tx_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_wr) begin found = 1'b1; break; end
    end
    chk("t6_wr_seen", found, 1);
    chk("t6_level_before", tx_level, 1);
    wr0 = wr_cnt;
    #2 res = 1'b1;
    #1;
    chk("t6_wr_dropped", uart_wr, 0);
    chk("t6_tx_level", tx_level, 0);
    chk("t6_rx_level", rx_level, 0);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_rx_stall", rx_stall, 0);
    @(negedge clk);
    #1 res = 1'b0;
    tick;
    chk("t6_tx_ready_after", tx_ready, 1);
    tx_valid = 1'b1; tx_data = 8'h66; tick;
    tx_valid = 1'b0;
    k = 2;
    while (k <= 20) begin
      @(negedge clk);
      if (uart_wr) break;
      k++;
    end
    chk("t6_first_wr_after_rst", k, 5);
    chk("t6_no_lost_handoff", wr_cnt, wr0);
    tick;
    chk("t6_wr_byte", wr_bytes[(wr_cnt - 1) % 256], 8'h66);
    repeat (12) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_stream_bridge.md
Name: uart_stream_bridge

Overview:
Bus-side companion to the UART peripheral. It sits between a byte-stream producer/consumer (boot loader, debug monitor, DMA engine) and the UART register port. It buffers TX bytes and RX bytes in two local FIFOs, and a small poll FSM drives the UART RD/WR/BE/DATAI strobes, moving bytes only when UART status permits. No core polling loop is needed.

Parameters:
DEPTH, 16, entries per FIFO; power of two, 2..256
POLL_GAP, 4, idle cycles between UART status polls; 0 means poll every cycle after SETTLE

Ports:
CLK  in  1  clock
RES  in  1  reset; asynchronous, active-high
TX_DATA  in  8  byte to transmit
TX_VALID  in  1  TX_DATA valid
TX_READY  out  1  TX FIFO not full
RX_DATA  out  8  head of RX FIFO
RX_VALID  out  1  RX FIFO not empty
RX_READY  in  1  consumer pops RX head
TX_LEVEL  out  $clog2(DEPTH)+1  TX FIFO occupancy
RX_LEVEL  out  $clog2(DEPTH)+1  RX FIFO occupancy
RX_STALL  out  1  sticky: UART had a byte while RX FIFO full
STALL_CLR  in  1  clears RX_STALL
UART_RD  out  1  UART bus read strobe
UART_WR  out  1  UART bus write strobe
UART_BE  out  4  UART byte enables
UART_DATAI  out  32  data to UART; byte in [15:8], all other bits 0
UART_DATAO  in  32  UART read data; [0] = xmit busy, [1] = recv ready, [15:8] = rx byte; combinational, valid in the same cycle

Behaviour:
- Reset (async, RES=1): both FIFOs empty; FSM enters IDLE with gap counter = POLL_GAP. All outputs are 0: TX_READY, RX_VALID, levels, RX_STALL, UART_RD, UART_WR, UART_BE, UART_DATAI. TX_READY rises the first cycle after RES deasserts.
- Reset mid-operation: any UART strobe drops immediately. An in-flight byte is either fully handed off (strobe already sampled by the UART) or remains lost with the FIFO contents; all FIFO contents are discarded.
- FIFOs: TX_READY=!tx_full; RX_VALID=!rx_empty. A push occurs on VALID&READY, a pop on RX_VALID&RX_READY.
- Push and pop in the same cycle are legal at any level; the level is unchanged.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. full = MSBs differ and the low bits are equal.
- RX_DATA is the registered head entry; it updates the cycle after a pop or the first push into an empty FIFO.
- FSM states: IDLE, POLL, RXPOP, TXPUSH, SETTLE.
- IDLE: decrement the gap counter; at 0, go to POLL.
- POLL: no strobes. Sample UART_DATAO[1:0].
  - Priority 1: DATAO[1]=1 and RX FIFO not full -> RXPOP.
  - Otherwise, DATAO[1]=1 with RX FIFO full -> set RX_STALL. The byte stays in the UART and may be overwritten there.
  - Priority 2: DATAO[0]=0 and TX FIFO not empty -> TXPUSH.
  - Otherwise -> IDLE and reload the gap counter.
- RXPOP (1 cycle): UART_RD=1, UART_BE=4'b0011. Push UART_DATAO[15:8] into the RX FIFO in this same cycle, then go to SETTLE.
- TXPUSH (1 cycle): UART_WR=1, UART_BE=4'b0010, UART_DATAI[15:8]=TX head. Pop TX in the same cycle, then go to SETTLE.
- SETTLE (1 cycle, no strobes): lets the UART status register update. Then go to POLL if POLL_GAP=0, else go to IDLE with counter = POLL_GAP.
- Strobes are registered outputs: exactly one strobe cycle per transferred byte, and never RD and WR together.
- Same-cycle FIFO interactions:
  - An RX push in RXPOP coinciding with a consumer pop is legal.
  - A TX pop in TXPUSH coinciding with a producer push is legal.
- STALL_CLR has priority over a same-cycle set.

Test Plan:
- Reset then push TX 0x41, 0x42 while UART busy=0 (POLL_GAP=4) -> exactly two UART_WR pulses, BE=4'b0010, DATAI=0x00004100 then 0x00004200. Pulses are ≥7 cycles apart; TX_LEVEL returns to 0.
- UART model sets DATAO[1]=1 with DATAO[15:8]=0x5A -> exactly one UART_RD, BE=4'b0011; RX_VALID=1 and RX_DATA=0x5A two cycles later; RX_LEVEL=1.
- Rx-ready and TX non-empty in the same POLL -> RXPOP happens first; TXPUSH happens on the next poll.
- Fill RX to DEPTH=16 with RX_READY=0 while the UART keeps DATAO[1]=1 -> no further UART_RD; RX_STALL=1. STALL_CLR pulse clears it; the next pop resumes transfers.
- Push 16 TX bytes while UART busy=1 -> TX_READY=0 at level 16, and the 17th push is ignored. Drop busy -> bytes drain in order 0..15, with the pointer wrap exercised by a second fill.
- Assert RES asynchronously during the TXPUSH cycle -> UART_WR falls the same cycle; levels read 0, RX_STALL=0, FSM in IDLE.
